// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests, response queue and IF_ID register.
// Optional perf counters are enabled with the FETCH_PERF_COUNTERS_EN macro.

package fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] fetched_inst;
        logic [31:0] pc;
    } if_id_t;

endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output if_id_t      if_id_reg,
    output logic        if_id_valid
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_bubble_count,
    output logic [31:0] fetch_redirect_count
`endif
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [AW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   q_inst_q [QUEUE_DEPTH];
    logic [31:0]   q_pc_q   [QUEUE_DEPTH];
    logic [31:0]   tag_q    [QUEUE_DEPTH];
    if_id_t        if_id_q, if_id_d;
    logic          if_id_valid_q, if_id_valid_d;

    logic [CW:0]   used_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          resp_s;
    logic          drop_resp_s;
    logic          push_s;
    logic          pop_s;
    logic          queue_empty_s;

    // Handshake qualification; responses with nothing outstanding (e.g. after reset) are ignored
    always_comb begin
        used_s        = {1'b0, inflight_q} + {1'b0, occ_q};
        queue_empty_s = (occ_q == CNT_ZERO);
        req_valid_s   = !reset && !redirect_valid && (used_s < {1'b0, DEPTH_C});
        accept_s      = req_valid_s && imem_req_ready;
        resp_s        = imem_resp_valid && (inflight_q != CNT_ZERO);
        drop_resp_s   = resp_s && (redirect_valid || (drop_cnt_q != CNT_ZERO));
        push_s        = resp_s && !drop_resp_s;
        pop_s         = !redirect_valid && !stall && !queue_empty_s;
    end

    // Outstanding request count, includes requests whose responses will be dropped
    always_comb begin
        inflight_d = inflight_q;
        if (accept_s && !resp_s) begin
            inflight_d = inflight_q + CNT_ONE;
        end else if (!accept_s && resp_s) begin
            inflight_d = inflight_q - CNT_ONE;
        end else begin
            inflight_d = inflight_q;
        end
    end

    // PC, drop counter, queue pointers and IF_ID next state
    always_comb begin
        pc_d          = pc_q;
        drop_cnt_d    = drop_cnt_q;
        occ_d         = occ_q;
        q_rd_d        = q_rd_q;
        q_wr_d        = q_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        if_id_d       = if_id_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect_valid) begin
            pc_d                 = redirect_pc & 32'hFFFF_FFFC;
            // Everything still outstanding after this edge is stale
            drop_cnt_d           = inflight_d;
            occ_d                = CNT_ZERO;
            q_rd_d               = PTR_ZERO;
            q_wr_d               = PTR_ZERO;
            tag_rd_d             = PTR_ZERO;
            tag_wr_d             = PTR_ZERO;
            if_id_d.fetched_inst = NOP_INST;
            if_id_d.pc           = 32'h0000_0000;
            if_id_valid_d        = 1'b0;
        end else begin
            if (accept_s) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + PTR_ONE;
            end else begin
                pc_d     = pc_q;
                tag_wr_d = tag_wr_q;
            end
            if (drop_resp_s) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (push_s) begin
                q_wr_d   = q_wr_q + PTR_ONE;
                tag_rd_d = tag_rd_q + PTR_ONE;
            end else begin
                q_wr_d   = q_wr_q;
                tag_rd_d = tag_rd_q;
            end
            if (pop_s) begin
                q_rd_d = q_rd_q + PTR_ONE;
            end else begin
                q_rd_d = q_rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase
            if (stall) begin
                if_id_d       = if_id_q;
                if_id_valid_d = if_id_valid_q;
            end else if (!queue_empty_s) begin
                if_id_d.fetched_inst = q_inst_q[q_rd_q];
                if_id_d.pc           = q_pc_q[q_rd_q];
                if_id_valid_d        = 1'b1;
            end else begin
                if_id_d.fetched_inst = NOP_INST;
                if_id_d.pc           = 32'h0000_0000;
                if_id_valid_d        = 1'b0;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= CNT_ZERO;
            drop_cnt_q    <= CNT_ZERO;
            occ_q         <= CNT_ZERO;
            q_rd_q        <= PTR_ZERO;
            q_wr_q        <= PTR_ZERO;
            tag_rd_q      <= PTR_ZERO;
            tag_wr_q      <= PTR_ZERO;
            if_id_q       <= '{fetched_inst: NOP_INST, pc: 32'h0000_0000};
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            drop_cnt_q    <= drop_cnt_d;
            occ_q         <= occ_d;
            q_rd_q        <= q_rd_d;
            q_wr_q        <= q_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            if_id_q       <= if_id_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Instruction queue and pc-tag storage; contents only read while occupied
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            q_inst_q[q_wr_q] <= imem_resp_data;
            q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
        end
        if (accept_s) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign if_id_reg      = if_id_q;
    assign if_id_valid    = if_id_valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] redirect_cnt_q;
    logic        bubble_s;

    always_comb begin
        bubble_s = !redirect_valid && !stall && queue_empty_s;
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q   <= 32'h0000_0000;
            redirect_cnt_q <= 32'h0000_0000;
        end else begin
            if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (redirect_valid && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_bubble_count   = bubble_cnt_q;
    assign fetch_redirect_count = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle in-order memory model plus hand-computed per-cycle expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    if_id_t      if_id_reg;
    logic        if_id_valid;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_bubble_count;
    logic [31:0] fetch_redirect_count;
`endif

    int          vectors;
    int          miscompares;
    logic        resp_en;
    logic [31:0] pend [$];

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .NOP_INST    (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .if_id_reg       (if_id_reg),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_bubble_count   (fetch_bubble_count),
        .fetch_redirect_count (fetch_redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns instruction = address + 0x1000_0000 one cycle after acceptance
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
        @(posedge clk);
        #1;
        if (resp_en && pend.size() != 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend.pop_front() + 32'h1000_0000;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0000_0000;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
        chk({tag, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, v});
        chk({tag, ".req_addr"}, imem_req_addr, addr);
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".if_valid"}, {31'h0, if_id_valid}, {31'h0, v});
        chk({tag, ".if_pc"}, if_id_reg.pc, v ? pc : 32'h0000_0000);
        chk({tag, ".if_inst"}, if_id_reg.fetched_inst, v ? (pc + 32'h1000_0000) : 32'h0000_0013);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0000_0000;
        stall           = 1'b0;
        resp_en         = 1'b1;

        // Reset state
        tick(); tick();
        chk_req("rst", 1'b0, 32'h0); chk_if("rst", 1'b0, 32'h0);
        reset = 1'b0; #1;
        chk_req("c0", 1'b1, 32'h0);

        // Streaming from reset
        tick(); chk_req("c1", 1'b1, 32'h4); chk_if("c1", 1'b0, 32'h0);
        tick(); chk_req("c2", 1'b0, 32'h8); chk_if("c2", 1'b0, 32'h0);
        tick(); chk_req("c3", 1'b1, 32'h8); chk_if("c3", 1'b1, 32'h0);

        // Memory not ready for 3 cycles at addr 8
        imem_req_ready = 1'b0;
        tick(); chk_req("c4", 1'b1, 32'h8); chk_if("c4", 1'b1, 32'h4);
        tick(); chk_req("c5", 1'b1, 32'h8); chk_if("c5", 1'b0, 32'h0);
        tick(); chk_req("c6", 1'b1, 32'h8); chk_if("c6", 1'b0, 32'h0);
        imem_req_ready = 1'b1;
        tick(); chk_req("c7", 1'b1, 32'hC); chk_if("c7", 1'b0, 32'h0);
        tick(); chk_req("c8", 1'b0, 32'h10); chk_if("c8", 1'b0, 32'h0);
        tick(); chk_req("c9", 1'b1, 32'h10); chk_if("c9", 1'b1, 32'h8);

        // Stall for 4 cycles while streaming
        stall = 1'b1;
        tick(); chk_req("c10", 1'b0, 32'h14); chk_if("c10", 1'b1, 32'h8);
        tick(); chk_req("c11", 1'b0, 32'h14); chk_if("c11", 1'b1, 32'h8);
        tick(); chk_req("c12", 1'b0, 32'h14); chk_if("c12", 1'b1, 32'h8);
        tick(); chk_req("c13", 1'b0, 32'h14); chk_if("c13", 1'b1, 32'h8);
        stall = 1'b0;
        tick(); chk_req("c14", 1'b1, 32'h14); chk_if("c14", 1'b1, 32'hC);
        tick(); chk_req("c15", 1'b1, 32'h18); chk_if("c15", 1'b1, 32'h10);
        tick(); chk_req("c16", 1'b0, 32'h1C); chk_if("c16", 1'b0, 32'h0);
        tick(); chk_req("c17", 1'b1, 32'h1C); chk_if("c17", 1'b1, 32'h14);

        // Build two outstanding fetches, then redirect to 0x100
        resp_en = 1'b0;
        tick(); chk_req("c18", 1'b1, 32'h20); chk_if("c18", 1'b1, 32'h18);
        tick(); chk_req("c19", 1'b0, 32'h24); chk_if("c19", 1'b0, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; resp_en = 1'b1; #1;
        chk_req("c19r", 1'b0, 32'h24);
        tick(); redirect_valid = 1'b0; #1;
        chk_req("c20", 1'b0, 32'h100); chk_if("c20", 1'b0, 32'h0);
        tick(); chk_req("c21", 1'b1, 32'h100); chk_if("c21", 1'b0, 32'h0);
        tick(); chk_req("c22", 1'b1, 32'h104); chk_if("c22", 1'b0, 32'h0);
        tick(); chk_req("c23", 1'b0, 32'h108); chk_if("c23", 1'b0, 32'h0);
        tick(); chk_req("c24", 1'b1, 32'h108); chk_if("c24", 1'b1, 32'h100);

        // Misaligned redirect coinciding with a response under stall
        stall = 1'b1;
        tick(); chk_req("c25", 1'b0, 32'h10C); chk_if("c25", 1'b1, 32'h100);
        chk("c25.resp_pending", {31'h0, imem_resp_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk_req("c25r", 1'b0, 32'h10C);
        tick(); redirect_valid = 1'b0; #1;
        chk_req("c26", 1'b1, 32'h100); chk_if("c26", 1'b0, 32'h0);
        stall = 1'b0;
        tick(); chk_req("c27", 1'b1, 32'h104); chk_if("c27", 1'b0, 32'h0);
        tick(); chk_req("c28", 1'b0, 32'h108); chk_if("c28", 1'b0, 32'h0);
        tick(); chk_req("c29", 1'b1, 32'h108); chk_if("c29", 1'b1, 32'h100);

        // Reset mid-stream
        reset = 1'b1; pend.delete(); #1;
        chk_req("c29rst", 1'b0, 32'h108);
        tick(); chk_req("c30", 1'b0, 32'h0); chk_if("c30", 1'b0, 32'h0);
        reset = 1'b0; #1;
        chk_req("c30rel", 1'b1, 32'h0);
        tick(); chk_req("c31", 1'b1, 32'h4); chk_if("c31", 1'b0, 32'h0);
        tick(); chk_req("c32", 1'b0, 32'h8); chk_if("c32", 1'b0, 32'h0);
        tick(); chk_req("c33", 1'b1, 32'h8); chk_if("c33", 1'b1, 32'h0);

        // Redirect to the top word: request forced low, then PC wraps to 0
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        chk_req("c33r", 1'b0, 32'h8);
        tick(); redirect_valid = 1'b0; #1;
        chk_req("c34", 1'b1, 32'hFFFF_FFFC); chk_if("c34", 1'b0, 32'h0);
        tick(); chk_req("c35", 1'b1, 32'h0); chk_if("c35", 1'b0, 32'h0);
        tick(); chk_req("c36", 1'b0, 32'h4); chk_if("c36", 1'b0, 32'h0);
        tick(); chk_req("c37", 1'b1, 32'h4); chk_if("c37", 1'b1, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf.redirects", fetch_redirect_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
